// File: rtl/bus_mul_pkg.sv
// Shared constants for the memory-mapped multiplier slave: register offsets, bit indices, FSM codes.
// No logic of its own; imported by the slave top and its datapath.
package bus_mul_pkg;

    localparam logic [7:0] OFF_OPA    = 8'h00;
    localparam logic [7:0] OFF_OPB    = 8'h01;
    localparam logic [7:0] OFF_CTRL   = 8'h02;
    localparam logic [7:0] OFF_STATUS = 8'h03;
    localparam logic [7:0] OFF_CLR    = 8'h04;
    localparam logic [7:0] OFF_RES_LO = 8'h05;
    localparam logic [7:0] OFF_RES_HI = 8'h06;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_IE_BIT    = 1;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int CLR_DONE_BIT   = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One decoded bus access for the current cycle.
    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [7:0] off;
    } bus_acc_t;

endpackage

// File: rtl/bus_mul_slave_mul_shift_add.sv
// Iterative unsigned shift-add multiplier: DATA_W cycles from start to done_pulse, product valid with done_pulse.
// No backpressure; start is ignored while busy, and product is only meaningful in the done_pulse cycle.
module mul_shift_add
    import bus_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done_pulse,
    output logic [2*DATA_W-1:0] product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] acc_step;
    logic                last;

    // Carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum      = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
        if (mplier_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        acc_step = {sum, acc_q[DATA_W-1:1]};
    end

    assign last = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done_pulse = last;
    assign product    = acc_step;

endmodule

// File: rtl/bus_mul_slave.sv
// Bus-mapped multiplier slave: register file, 1-cycle registered read data, DATA_W-cycle multiply, level irq.
// No backpressure: every selected access completes in its cycle; a start while executing is dropped.
module bus_mul_slave
    import bus_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [7:0]        S_addr,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    output logic              irq
);

    bus_acc_t acc;

    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   res_lo_q, res_lo_d;
    logic [DATA_W-1:0]   res_hi_q, res_hi_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                ie_q, ie_d;
    logic                done_q, done_d;
    logic [1:0]          state_q, state_d;

    logic                ctrl_wr, clr_wr, start_acc;
    logic [DATA_W-1:0]   rdata;
    logic                mul_busy, mul_done;
    logic [2*DATA_W-1:0] mul_product;

    logic unused_addr_hi;
    assign unused_addr_hi = ^S_addr[7:OFF_W];

    always_comb begin
        acc.wr  = S_sel && S_wr;
        acc.rd  = S_sel && !S_wr;
        acc.off = 8'(S_addr[OFF_W-1:0]);
    end

    assign ctrl_wr   = acc.wr && (acc.off == OFF_CTRL);
    assign clr_wr    = acc.wr && (acc.off == OFF_CLR) && S_din[CLR_DONE_BIT];
    assign start_acc = ctrl_wr && S_din[CTRL_START_BIT] && (state_q != ST_EXEC);

    mul_shift_add #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_acc),
        .a          (opa_q),
        .b          (opb_q),
        .busy       (mul_busy),
        .done_pulse (mul_done),
        .product    (mul_product)
    );

    always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        ie_d  = ie_q;
        if (acc.wr && (acc.off == OFF_OPA)) opa_d = S_din;
        if (acc.wr && (acc.off == OFF_OPB)) opb_d = S_din;
        if (ctrl_wr)                        ie_d  = S_din[CTRL_IE_BIT];
    end

    always_comb begin
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        if (mul_done) begin
            res_lo_d = mul_product[DATA_W-1:0];
            res_hi_d = mul_product[2*DATA_W-1:DATA_W];
        end
    end

    // CLR only acts outside EXEC, so completion always leaves done set.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_EXEC;
                    done_d  = 1'b0;
                end
            end
            ST_EXEC: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start_acc) begin
                    state_d = ST_EXEC;
                    done_d  = 1'b0;
                end else if (clr_wr) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        case (acc.off)
            OFF_OPA:    rdata = opa_q;
            OFF_OPB:    rdata = opb_q;
            OFF_CTRL:   rdata[CTRL_IE_BIT] = ie_q;
            OFF_STATUS: begin
                rdata[STAT_BUSY_BIT] = mul_busy;
                rdata[STAT_DONE_BIT] = done_q;
            end
            OFF_RES_LO: rdata = res_lo_q;
            OFF_RES_HI: rdata = res_hi_q;
            default:    rdata = '0;
        endcase
        dout_d = acc.rd ? rdata : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dout_q   <= '0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dout_q   <= dout_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            state_q  <= state_d;
        end
    end

    assign S_dout = dout_q;
    assign irq    = done_q & ie_q;

endmodule

// File: tb/tb_bus_mul_slave.sv
// Directed bench for bus_mul_slave: register access, multiply timing/results, irq, mid-op behaviour, async reset.
module tb_bus_mul_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        S_sel = 1'b0;
    logic        S_wr = 1'b0;
    logic [7:0]  S_addr = 8'h00;
    logic [31:0] S_din = 32'h0;
    logic [31:0] S_dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    bus_mul_slave #(.DATA_W(32), .OFF_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .S_sel   (S_sel),
        .S_wr    (S_wr),
        .S_addr  (S_addr),
        .S_din   (S_din),
        .S_dout  (S_dout),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        S_sel = 1'b1; S_wr = 1'b1; S_addr = a; S_din = d;
        @(negedge clk);
        S_sel = 1'b0; S_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        S_sel = 1'b1; S_wr = 1'b0; S_addr = a;
        @(posedge clk);
        #1 d = S_dout;
        @(negedge clk);
        S_sel = 1'b0;
    endtask

    // Called right after a start write: streams STATUS reads, counts busy samples until the first non-busy one.
    task automatic count_busy(output int n, output logic [31:0] fin);
        n = 0;
        fin = 32'hFFFF_FFFF;
        S_sel = 1'b1; S_wr = 1'b0; S_addr = 8'h03;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (S_dout[0] === 1'b1) n++;
            else begin
                fin = S_dout;
                break;
            end
        end
        @(negedge clk);
        S_sel = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        checks++;
        if (S_dout !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: S_dout=%h irq=%b, want 0/0", S_dout, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(8'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_read_off%0d: got %h, want 0", a, d);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b, want 0", irq);
        end
    endtask

    task automatic test_mul_basic;
        logic [31:0] d, fin;
        int n;
        bus_write(8'h00, 32'd3);
        bus_write(8'h01, 32'd5);
        bus_write(8'h02, 32'h1);
        count_busy(n, fin);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 32", n);
        end
        checks++;
        if (fin !== 32'h2) begin
            errors++;
            $display("FAIL basic_status_done: got %h, want 00000002", fin);
        end
        bus_read(8'h05, d);
        checks++;
        if (d !== 32'h0000_000F) begin
            errors++;
            $display("FAIL basic_res_lo: got %h, want 0000000f", d);
        end
        bus_read(8'h06, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL basic_res_hi: got %h, want 0", d);
        end
        @(posedge clk);
        #1;
        checks++;
        if (S_dout !== 32'h0) begin
            errors++;
            $display("FAIL idle_dout_zero: got %h, want 0", S_dout);
        end
    endtask

    task automatic test_max_irq;
        logic [31:0] d;
        int rise;
        bus_write(8'h00, 32'hFFFF_FFFF);
        bus_write(8'h01, 32'hFFFF_FFFF);
        bus_write(8'h02, 32'h3);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL max_irq_after_start: got %b, want 0", irq);
        end
        rise = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (irq === 1'b1) begin
                rise = k;
                break;
            end
        end
        checks++;
        if (rise !== 32) begin
            errors++;
            $display("FAIL max_irq_rise_edge: got %0d, want 32", rise);
        end
        bus_read(8'h06, d);
        checks++;
        if (d !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL max_res_hi: got %h, want fffffffe", d);
        end
        bus_read(8'h05, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL max_res_lo: got %h, want 00000001", d);
        end
        bus_write(8'h02, 32'h0);
        bus_read(8'h03, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h2) begin
            errors++;
            $display("FAIL ie_mask: irq=%b status=%h, want 0/00000002", irq, d);
        end
        bus_write(8'h02, 32'h2);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL ie_unmask: irq=%b, want 1", irq);
        end
        bus_write(8'h04, 32'h1);
        bus_read(8'h03, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL clr_done: irq=%b status=%h, want 0/00000000", irq, d);
        end
        bus_read(8'h02, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL ctrl_readback: got %h, want 00000002", d);
        end
    endtask

    task automatic test_mid_exec;
        logic [31:0] d, fin;
        int n;
        bus_write(8'h00, 32'd6);
        bus_write(8'h01, 32'd7);
        bus_write(8'h02, 32'h1);
        bus_write(8'h00, 32'd7);
        bus_write(8'h02, 32'h1);
        bus_write(8'h04, 32'h1);
        bus_read(8'h05, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mid_res_lo_old: got %h, want 00000001", d);
        end
        bus_read(8'h03, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL mid_status_busy: got %h, want 00000001", d);
        end
        count_busy(n, fin);
        checks++;
        if (fin !== 32'h2) begin
            errors++;
            $display("FAIL mid_done_after_clr: got %h, want 00000002", fin);
        end
        bus_read(8'h05, d);
        checks++;
        if (d !== 32'd42) begin
            errors++;
            $display("FAIL mid_res_lo: got %h, want 0000002a", d);
        end
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'd7) begin
            errors++;
            $display("FAIL mid_opa_updated: got %h, want 00000007", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_irq_ie0: got %b, want 0", irq);
        end
    endtask

    task automatic test_zero_mul;
        logic [31:0] d, fin;
        int n;
        bus_write(8'h00, 32'd0);
        bus_write(8'h01, 32'd9);
        bus_write(8'h02, 32'h1);
        count_busy(n, fin);
        checks++;
        if (n !== 32 || fin !== 32'h2) begin
            errors++;
            $display("FAIL zero_timing: busy=%0d status=%h, want 32/00000002", n, fin);
        end
        bus_read(8'h05, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL zero_res_lo: got %h, want 0", d);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] d;
        bus_write(8'h00, 32'd3);
        bus_write(8'h01, 32'd5);
        bus_write(8'h02, 32'h3);
        S_sel = 1'b1; S_wr = 1'b0; S_addr = 8'h03;
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (S_dout !== 32'h1) begin
            errors++;
            $display("FAIL rst_pre_busy: got %h, want 00000001", S_dout);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (S_dout !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: S_dout=%h irq=%b, want 0/0", S_dout, irq);
        end
        S_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 2; a < 7; a++) begin
            bus_read(8'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL rst_after_off%0d: got %h, want 0", a, d);
            end
        end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        bus_write(8'h00, 32'h1234_5678);
        @(negedge clk);
        S_sel = 1'b0; S_wr = 1'b1; S_addr = 8'h00; S_din = 32'hAA;
        @(negedge clk);
        S_wr = 1'b0;
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL unselected_write: got %h, want 12345678", d);
        end
        bus_read(8'h1F, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h, want 0", d);
        end
        bus_write(8'h05, 32'hDEAD_BEEF);
        bus_read(8'h05, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL ro_write_ignored: got %h, want 0", d);
        end
        bus_read(8'h20, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL addr_upper_ignored: got %h, want 12345678", d);
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_mul_basic();
        test_max_irq();
        test_mid_exec();
        test_zero_mul();
        test_reset_mid_op();
        test_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
